// File: rtl/apb_txn_tracer.sv
// Passive APB observer: protocol checker, statistics counters and a trace FIFO
// of completed transfers drained through a valid/ready port. Never drives the bus.
module apb_txn_tracer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    parameter int IRQ_N  = 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic [IRQ_N-1:0]  irq,
    input  logic              clr_stats,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic              trc_write,
    output logic [ADDR_W-1:0] trc_addr,
    output logic [DATA_W-1:0] trc_data,
    output logic              trc_err,
    output logic [7:0]        trc_wait,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  slverr_cnt,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [CNT_W-1:0]  irq_rise_cnt,
    output logic [2:0]        proto_err,
    output logic [IRQ_N-1:0]  irq_rise
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W + 1 + 8;
    localparam int N_CNT   = 5;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wait_q, wait_d;
    logic [2:0]        perr_set;
    logic              complete;
    logic [ENTRY_W-1:0] push_entry;

    // ------------------------------------------------------------------
    // Transfer tracking FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        wait_d   = wait_q;
        perr_set = 3'b000;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL) begin
                    if (!PENABLE) begin
                        addr_d  = PADDR;
                        write_d = PWRITE;
                        wdata_d = PWDATA;
                        wait_d  = 8'd0;
                        state_d = ACCESS;
                    end else begin
                        perr_set[0] = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    perr_set[2] = 1'b1;
                    state_d     = IDLE;
                end else if (!PENABLE) begin
                    // A repeated SETUP restarts the transfer with fresh values.
                    perr_set[0] = 1'b1;
                    addr_d      = PADDR;
                    write_d     = PWRITE;
                    wdata_d     = PWDATA;
                    wait_d      = 8'd0;
                end else begin
                    if ((PADDR != addr_q) || (PWRITE != write_q) ||
                        (write_q && (PWDATA != wdata_q))) begin
                        perr_set[1] = 1'b1;
                    end
                    if (PREADY) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else if (wait_q != 8'hFF) begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_entry = {write_q, addr_q, (write_q ? PWDATA : PRDATA), PSLVERR, wait_q};
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
        end
    end

    // ------------------------------------------------------------------
    // Trace FIFO; the extra pointer bit separates full from empty
    // ------------------------------------------------------------------
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic               fifo_empty, fifo_full;
    logic               pop, push_ok, drop;

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop        = !fifo_empty && trc_ready;
        push_ok    = complete && (!fifo_full || pop);
        drop       = complete && fifo_full && !pop;
        wr_ptr_d   = push_ok ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = pop ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= push_entry;
        end
    end

    // Storage is not reset, so the head is forced to zero while empty.
    always_comb begin
        head = fifo_empty ? '0 : mem[rd_ptr_q[PTR_W-1:0]];
    end

    assign trc_valid = !fifo_empty;
    assign trc_write = head[ENTRY_W-1];
    assign trc_addr  = head[ENTRY_W-2 -: ADDR_W];
    assign trc_data  = head[9 +: DATA_W];
    assign trc_err   = head[8];
    assign trc_wait  = head[7:0];

    // ------------------------------------------------------------------
    // Interrupt edge detection
    // ------------------------------------------------------------------
    logic [IRQ_N-1:0] irq_q, irq_d;
    logic [IRQ_N-1:0] irq_rise_q, irq_rise_d;

    always_comb begin
        irq_d      = irq;
        irq_rise_d = irq & ~irq_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_q      <= '0;
            irq_rise_q <= '0;
        end else begin
            irq_q      <= irq_d;
            irq_rise_q <= irq_rise_d;
        end
    end

    assign irq_rise = irq_rise_q;

    // ------------------------------------------------------------------
    // Saturating statistics counters and sticky protocol errors
    // ------------------------------------------------------------------
    logic [N_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_q [N_CNT];
    logic [CNT_W-1:0] cnt_d [N_CNT];
    logic [2:0]       proto_q, proto_d;

    always_comb begin
        cnt_inc[0] = complete && write_q;
        cnt_inc[1] = complete && !write_q;
        cnt_inc[2] = complete && PSLVERR;
        cnt_inc[3] = drop;
        cnt_inc[4] = |irq_rise_d;
        proto_d    = clr_stats ? 3'b000 : (proto_q | perr_set);
    end

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            assign cnt_d[gi] = clr_stats ? '0 :
                               (cnt_inc[gi] && !(&cnt_q[gi])) ? (cnt_q[gi] + 1'b1) :
                               cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            proto_q <= 3'b000;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            proto_q <= proto_d;
        end
    end

    assign wr_cnt       = cnt_q[0];
    assign rd_cnt       = cnt_q[1];
    assign slverr_cnt   = cnt_q[2];
    assign ovf_cnt      = cnt_q[3];
    assign irq_rise_cnt = cnt_q[4];
    assign proto_err    = proto_q;

endmodule

// File: doc/apb_txn_tracer.md
Name: apb_txn_tracer

Overview:
Synthesizable passive APB observer and successor to the simulation-only bus monitor. It is parametrised in address width, data width, trace depth and interrupt-line count. It checks APB protocol sequencing, counts transactions, errors and wait states, and captures completed transfers into a trace FIFO drained through a valid/ready port. It sits beside any APB slave (GPIO, strap, timer) in silicon or emulation and never drives the bus.

Parameters:
ADDR_W, 6, PADDR width
DATA_W, 32, PWDATA/PRDATA width
DEPTH, 8, trace FIFO entries; power of 2, at least 2
CNT_W, 16, width of every statistics counter
IRQ_N, 1, number of monitored interrupt lines

Ports:
PCLK  in  1  bus clock
PRESETn  in  1  reset, asynchronous assert, active-low
PSEL, PENABLE, PWRITE, PREADY, PSLVERR  in  1 each  observed APB control
PADDR  in  ADDR_W  observed address
PWDATA, PRDATA  in  DATA_W  observed data
irq  in  IRQ_N  observed interrupt lines
clr_stats  in  1  single-cycle clear of counters and sticky errors
trc_valid  out  1  FIFO head valid
trc_ready  in  1  consumer pop
trc_write  out  1  head: 1=write
trc_addr  out  ADDR_W  head address
trc_data  out  DATA_W  head data (PWDATA for writes, PRDATA for reads, sampled at completion)
trc_err  out  1  head PSLVERR
trc_wait  out  8  head wait-state count, saturating at 255
wr_cnt, rd_cnt, slverr_cnt, ovf_cnt, irq_rise_cnt  out  CNT_W each  statistics
proto_err  out  3  sticky protocol errors
irq_rise  out  IRQ_N  one-cycle registered pulse per line on a rising edge

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, irq history 0.
- All sampling happens on PCLK rising edges. There is no combinational path from bus inputs to outputs.
- FSM IDLE:
  - PSEL=1, PENABLE=0: latch PADDR, PWRITE and PWDATA, clear the wait counter, go to ACCESS.
  - PSEL=1, PENABLE=1: set proto_err[0] (sequence error) and stay in IDLE.
- FSM ACCESS (PSEL=1, PENABLE=1):
  - If PADDR, PWRITE or (for writes) PWDATA differs from the latched value, set proto_err[1].
  - PREADY=0: increment the wait counter, saturating at 255, and stay in ACCESS.
  - PREADY=1: complete the transfer, push an entry, go to IDLE.
  - A back-to-back SETUP in the next cycle is then accepted from IDLE, so consecutive transfers need no idle gap.
- ACCESS with PSEL=1, PENABLE=0: set proto_err[0]. Treat the cycle as a new SETUP (re-latch) and stay in ACCESS.
- ACCESS with PSEL=0: set proto_err[2] (abort). Go to IDLE with no push.
- On completion:
  - Increment wr_cnt or rd_cnt.
  - Increment slverr_cnt if PSLVERR=1.
- FIFO:
  - trc_valid = not empty. Head fields are registered.
  - Pop when trc_valid & trc_ready.
  - A completion lands in an empty FIFO with trc_valid high the cycle after the completion edge.
  - Push while full with no simultaneous pop: drop the entry and increment ovf_cnt. Existing entries are unchanged.
  - Push and pop together while full: both succeed, no drop.
  - Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- irq:
  - irq_rise[i] = irq[i] & ~irq_q[i], registered.
  - irq_rise_cnt increments by 1 in any cycle where at least one line rises; simultaneous rises on several lines still count once.
- Counters saturate at all-ones and never wrap.
- clr_stats:
  - Zeroes all five counters and proto_err in the next cycle.
  - Clear wins over a simultaneous increment.
  - Does not affect the FIFO, the FSM or the irq history.
- Reset mid-transfer: the FSM returns to IDLE, the FIFO is emptied and any partial transfer is discarded.

Test Plan:
- Write 0xA5A5_0001 to 0x04 with zero waits, then read 0x08 returning 0x0000_00FF with 2 waits -> two entries in order: {1,0x04,0xA5A50001,err 0,wait 0}, {0,0x08,0x000000FF,err 0,wait 2}; wr_cnt=1, rd_cnt=1, proto_err=0.
- Hold trc_ready=0 and issue DEPTH+3 writes -> trc_valid=1, ovf_cnt=3, and draining returns the first DEPTH entries in order. Then, at full, complete a write in the same cycle as a pop -> no drop, ovf_cnt stays 3.
- Violations:
  - PENABLE=1 from IDLE -> proto_err=3'b001.
  - PADDR changed during a wait state -> bit1 set.
  - PSEL dropped before PREADY -> bit2 set, no FIFO entry.
- PSLVERR=1 on a read completion -> trc_err=1 and slverr_cnt=1. Then clr_stats coinciding with another error completion -> slverr_cnt=0 and proto_err=0 the next cycle, while the FIFO still holds 2 entries.
- IRQ_N=2: both lines rise in the same cycle, then line 0 falls and rises again -> irq_rise=2'b11, then 2'b01; irq_rise_cnt=2.
- Assert PRESETn low during a 3-wait read -> all outputs 0 immediately, and no entry appears after release.
